// File: rtl/alu_issue.sv
// Issue stage for the execute-stage ALU: decodes a MIPS word into ALU operands,
// opcode and destination, then holds the result in an output register plus a one-entry skid register.
module alu_issue #(
  parameter int SIZEDATA = 32,
  parameter int SIZEOP   = 6,
  parameter int SIZEREG  = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [31:0]         i_instruction,
  input  logic [SIZEDATA-1:0] i_rs_data,
  input  logic [SIZEDATA-1:0] i_rt_data,
  input  logic                i_flush,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZEDATA-1:0] o_datoa,
  output logic [SIZEDATA-1:0] o_datob,
  output logic [SIZEOP-1:0]   o_opcode,
  output logic [SIZEREG-1:0]  o_rd,
  output logic                o_regwrite,
  output logic                o_illegal
);

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  typedef struct packed {
    logic [SIZEDATA-1:0] a;
    logic [SIZEDATA-1:0] b;
    logic [SIZEOP-1:0]   opcode;
    logic [SIZEREG-1:0]  rd;
    logic                regwrite;
    logic                illegal;
  } payload_t;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign op    = i_instruction[31:26];
  assign rt    = i_instruction[20:16];
  assign rd    = i_instruction[15:11];
  assign shamt = i_instruction[10:6];
  assign funct = i_instruction[5:0];
  assign imm   = i_instruction[15:0];
  // rs arrives already read as i_rs_data; its index field has no use here.
  assign unused_rs_field = ^i_instruction[25:21];

  payload_t dec;
  logic     legal;

  // Illegal words decode to an all-zero payload with only the illegal flag set.
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        unique case (funct)
          F_SLL, F_SRL, F_SRA: begin
            legal      = 1'b1;
            dec.a      = i_rt_data;
            dec.b      = SIZEDATA'(shamt);
            dec.opcode = SIZEOP'(funct);
            dec.rd     = SIZEREG'(rd);
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            legal      = 1'b1;
            dec.a      = i_rt_data;
            dec.b      = SIZEDATA'(i_rs_data[4:0]);
            dec.opcode = SIZEOP'(funct);
            dec.rd     = SIZEREG'(rd);
          end
          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT: begin
            legal      = 1'b1;
            dec.a      = i_rs_data;
            dec.b      = i_rt_data;
            dec.opcode = SIZEOP'(funct);
            dec.rd     = SIZEREG'(rd);
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_SLTI: begin
        legal      = 1'b1;
        dec.a      = i_rs_data;
        dec.b      = {{(SIZEDATA-16){imm[15]}}, imm};
        dec.opcode = SIZEOP'(op);
        dec.rd     = SIZEREG'(rt);
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        legal      = 1'b1;
        dec.a      = i_rs_data;
        dec.b      = {{(SIZEDATA-16){1'b0}}, imm};
        dec.opcode = SIZEOP'(op);
        dec.rd     = SIZEREG'(rt);
      end
      OP_LUI: begin
        legal      = 1'b1;
        dec.a      = {{(SIZEDATA-16){1'b0}}, imm};
        dec.b      = SIZEDATA'(16);
        dec.opcode = SIZEOP'(op);
        dec.rd     = SIZEREG'(rt);
      end
      default: legal = 1'b0;
    endcase
    dec.illegal  = !legal;
    dec.regwrite = legal && (dec.rd != '0);
  end

  payload_t out_q, skid_q;
  logic     out_full, skid_full;
  logic     accept, drain;

  assign accept = i_valid && !skid_full && !i_flush;
  assign drain  = out_full && i_ready;

  // Two-entry FIFO: the skid entry only fills while OUT is stalled, so
  // o_ready can come straight from a flop without losing the in-flight word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      out_q     <= '0;
      skid_q    <= '0;
      out_full  <= 1'b0;
      skid_full <= 1'b0;
    end else if (i_flush) begin
      out_full  <= 1'b0;
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (drain) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (!out_full || drain) begin
        out_q    <= dec;
        out_full <= 1'b1;
      end else begin
        skid_q    <= dec;
        skid_full <= 1'b1;
      end
    end else if (drain) begin
      out_full <= 1'b0;
    end
  end

  assign o_valid    = out_full;
  assign o_ready    = !skid_full;
  assign o_datoa    = out_q.a;
  assign o_datob    = out_q.b;
  assign o_opcode   = out_q.opcode;
  assign o_rd       = out_q.rd;
  assign o_regwrite = out_q.regwrite;
  assign o_illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vectors, backpressure through the skid
// entry, flush, illegal words and mid-stream reset, with hand-computed expectations.
module tb_alu_issue;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_flush, i_ready;
  logic [31:0] i_instruction, i_rs_data, i_rt_data;
  logic        o_ready, o_valid, o_regwrite, o_illegal;
  logic [31:0] o_datoa, o_datob;
  logic [5:0]  o_opcode;
  logic [4:0]  o_rd;

  int checks = 0;
  int failures = 0;

  alu_issue dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_datoa(o_datoa), .o_datob(o_datob), .o_opcode(o_opcode), .o_rd(o_rd),
    .o_regwrite(o_regwrite), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  // Drive inputs, pass one rising edge, then settle before outputs are sampled.
  task automatic apply_stimulus(input logic valid, input logic [31:0] instr,
                                input logic [31:0] rs, input logic [31:0] rt,
                                input logic ready, input logic flush);
    i_valid = valid; i_instruction = instr; i_rs_data = rs; i_rt_data = rt;
    i_ready = ready; i_flush = flush;
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_payload(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [5:0] opc, input logic [4:0] rd,
                               input logic rw, input logic ill);
    check_output({tag, ".valid"}, 32'(o_valid), 32'd1);
    check_output({tag, ".a"}, o_datoa, a);
    check_output({tag, ".b"}, o_datob, b);
    check_output({tag, ".opcode"}, 32'(o_opcode), 32'(opc));
    check_output({tag, ".rd"}, 32'(o_rd), 32'(rd));
    check_output({tag, ".regwrite"}, 32'(o_regwrite), 32'(rw));
    check_output({tag, ".illegal"}, 32'(o_illegal), 32'(ill));
  endtask

  task automatic check_empty_reset_state(input string tag);
    check_output({tag, ".valid"}, 32'(o_valid), 32'd0);
    check_output({tag, ".ready"}, 32'(o_ready), 32'd1);
    check_output({tag, ".a"}, o_datoa, 32'd0);
    check_output({tag, ".b"}, o_datob, 32'd0);
    check_output({tag, ".opcode"}, 32'(o_opcode), 32'd0);
    check_output({tag, ".rd"}, 32'(o_rd), 32'd0);
    check_output({tag, ".regwrite"}, 32'(o_regwrite), 32'd0);
    check_output({tag, ".illegal"}, 32'(o_illegal), 32'd0);
  endtask

  initial begin
    $display("[TB] alu_issue directed test start");
    i_reset = 1'b1;
    apply_stimulus(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b0);
    check_empty_reset_state("reset");
    i_reset = 1'b0;

    // Back-to-back decode vectors at full throughput.
    apply_stimulus(1'b1, 32'h00221821, 32'd5, 32'd7, 1'b1, 1'b0);
    check_payload("addu", 32'd5, 32'd7, 6'b100001, 5'd3, 1'b1, 1'b0);
    check_output("addu.ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b1, 32'h00011100, 32'd9, 32'd1, 1'b1, 1'b0);
    check_payload("sll", 32'd1, 32'd4, 6'b000000, 5'd2, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00A41807, 32'hFFFFFFE3, 32'h80000000, 1'b1, 1'b0);
    check_payload("srav", 32'h80000000, 32'd3, 6'b000111, 5'd3, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h2022FFFF, 32'd10, 32'd0, 1'b1, 1'b0);
    check_payload("addi", 32'd10, 32'hFFFFFFFF, 6'b001000, 5'd2, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h28A38000, 32'd11, 32'd0, 1'b1, 1'b0);
    check_payload("slti", 32'd11, 32'hFFFF8000, 6'b001010, 5'd3, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h3422FFFF, 32'd12, 32'd0, 1'b1, 1'b0);
    check_payload("ori", 32'd12, 32'h0000FFFF, 6'b001101, 5'd2, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h3C051234, 32'd13, 32'd14, 1'b1, 1'b0);
    check_payload("lui", 32'h00001234, 32'd16, 6'b001111, 5'd5, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00000000, 32'd3, 32'd7, 1'b1, 1'b0);
    check_payload("nop", 32'd7, 32'd0, 6'b000000, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00220021, 32'd1, 32'd2, 1'b1, 1'b0);
    check_payload("addu_r0", 32'd1, 32'd2, 6'b100001, 5'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00221820, 32'd1, 32'd2, 1'b1, 1'b0);
    check_payload("add_illegal", 32'd0, 32'd0, 6'b000000, 5'd0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_output("drain.valid", 32'(o_valid), 32'd0);

    // Backpressure: I1 to OUT, I2 to SKID, I3 held upstream until o_ready returns.
    apply_stimulus(1'b1, 32'h00221821, 32'd101, 32'd0, 1'b0, 1'b0);
    check_output("bp.i1.a", o_datoa, 32'd101);
    check_output("bp.i1.ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b1, 32'h00221821, 32'd102, 32'd0, 1'b0, 1'b0);
    check_output("bp.i2.ready", 32'(o_ready), 32'd0);
    check_output("bp.i2.hold_a", o_datoa, 32'd101);
    apply_stimulus(1'b1, 32'h00221821, 32'd103, 32'd0, 1'b0, 1'b0);
    check_output("bp.i3.ready", 32'(o_ready), 32'd0);
    check_payload("bp.hold", 32'd101, 32'd0, 6'b100001, 5'd3, 1'b1, 1'b0);
    apply_stimulus(1'b1, 32'h00221821, 32'd103, 32'd0, 1'b1, 1'b0);
    check_output("bp.out2.valid", 32'(o_valid), 32'd1);
    check_output("bp.out2.a", o_datoa, 32'd102);
    check_output("bp.out2.ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b1, 32'h00221821, 32'd103, 32'd0, 1'b1, 1'b0);
    check_output("bp.out3.valid", 32'(o_valid), 32'd1);
    check_output("bp.out3.a", o_datoa, 32'd103);
    apply_stimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_output("bp.done.valid", 32'(o_valid), 32'd0);
    apply_stimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_output("bp.nodup.valid", 32'(o_valid), 32'd0);

    // Flush with both entries full and a valid incoming word.
    apply_stimulus(1'b1, 32'h00221821, 32'd201, 32'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00221821, 32'd202, 32'd0, 1'b0, 1'b0);
    check_output("fl.full.ready", 32'(o_ready), 32'd0);
    apply_stimulus(1'b1, 32'h00221821, 32'd203, 32'd0, 1'b1, 1'b1);
    check_output("fl.valid", 32'(o_valid), 32'd0);
    check_output("fl.ready", 32'(o_ready), 32'd1);
    apply_stimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_output("fl.after.valid", 32'(o_valid), 32'd0);
    apply_stimulus(1'b1, 32'h8C220000, 32'd5, 32'd6, 1'b1, 1'b0);
    check_payload("lw_illegal", 32'd0, 32'd0, 6'b000000, 5'd0, 1'b0, 1'b1);

    // Reset in the middle of a stall discards both entries and ignores inputs.
    apply_stimulus(1'b1, 32'h00221821, 32'd301, 32'd0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00221821, 32'd302, 32'd0, 1'b0, 1'b0);
    i_reset = 1'b1;
    apply_stimulus(1'b1, 32'h00221821, 32'd303, 32'd0, 1'b1, 1'b0);
    check_empty_reset_state("midreset");
    i_reset = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    check_output("midreset.after.valid", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
